// File: rtl/cpu_pkg.sv
// Shared types for the lab8 CPU control unit: state encodings, opcodes, branch conditions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ALU    = 3'd3,
        ST_LOAD   = 3'd4,
        ST_STORE  = 3'd5,
        ST_BRANCH = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    localparam logic [3:0] OP_LD  = 4'hC;
    localparam logic [3:0] OP_ST  = 4'hD;
    localparam logic [3:0] OP_BR  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Branch condition field IR[11:9]; codes 101-111 are never taken.
    localparam logic [2:0] BC_ALWAYS = 3'b000;
    localparam logic [2:0] BC_Z      = 3'b001;
    localparam logic [2:0] BC_N      = 3'b010;
    localparam logic [2:0] BC_C      = 3'b011;
    localparam logic [2:0] BC_NZ     = 3'b100;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
    } flags_t;

    typedef struct packed {
        logic w_en;
        logic s_sel;
        logic pc_ld;
        logic pc_inc;
        logic ir_ld;
        logic adr_sel;
        logic mw_en;
        logic halted;
    } ctrl_t;

    // Execute state selected by the opcode in DECODE; everything below 0xC is an ALU op.
    function automatic state_e op_to_state(input logic [3:0] op);
        case (op)
            OP_LD:   return ST_LOAD;
            OP_ST:   return ST_STORE;
            OP_BR:   return ST_BRANCH;
            OP_HLT:  return ST_HALT;
            default: return ST_ALU;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] cond, input flags_t f);
        case (cond)
            BC_ALWAYS: return 1'b1;
            BC_Z:      return f.z;
            BC_N:      return f.n;
            BC_C:      return f.c;
            BC_NZ:     return !f.z;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_cu_if.sv
// Control-unit <-> execution-unit bundle: IR/flags in, control strobes and debug out.
// Latency: n/a (wires only).
// Backpressure: none.
interface cpu_cu_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      IR;
    logic             N;
    logic             Z;
    logic             C;
    logic             W_En;
    logic             S_Sel;
    logic             pc_ld;
    logic             pc_inc;
    logic             ir_ld;
    logic             adr_sel;
    logic             mw_en;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    // Execution-unit side: supplies IR and status flags, consumes controls.
    modport master (
        output IR, N, Z, C,
        input  W_En, S_Sel, pc_ld, pc_inc, ir_ld, adr_sel, mw_en, halted, state, instr_cnt
    );

    // Control-unit side.
    modport slave (
        input  IR, N, Z, C,
        output W_En, S_Sel, pc_ld, pc_inc, ir_ld, adr_sel, mw_en, halted, state, instr_cnt
    );
endinterface

// File: rtl/cpu_cu_decode.sv
// Combinational map from FSM state (plus branch condition and latched flags) to control strobes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. Branch evaluation only exists when CPU_CU_BRANCH_EN is defined.
module cpu_cu_decode
    import cpu_pkg::*;
(
    input  state_e     state_i,
`ifdef CPU_CU_BRANCH_EN
    input  logic [2:0] br_cond_i,
    input  flags_t     flags_i,
`endif
    output ctrl_t      ctrl_o
);

    // Moore decode: every strobe is low unless the current state asserts it.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.ir_ld  = 1'b1;
                ctrl_o.pc_inc = 1'b1;
            end
            ST_ALU: begin
                ctrl_o.w_en = 1'b1;
            end
            ST_LOAD: begin
                ctrl_o.adr_sel = 1'b1;
                ctrl_o.s_sel   = 1'b1;
                ctrl_o.w_en    = 1'b1;
            end
            ST_STORE: begin
                ctrl_o.adr_sel = 1'b1;
                ctrl_o.mw_en   = 1'b1;
            end
            ST_BRANCH: begin
`ifdef CPU_CU_BRANCH_EN
                ctrl_o.pc_ld = branch_taken(br_cond_i, flags_i);
`else
                ctrl_o.pc_ld = 1'b0;
`endif
            end
            ST_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_cu.sv
// Multi-cycle FETCH/DECODE/EXEC control unit for the lab8 16-bit CPU (CPU_CU_BRANCH_EN enables branches).
// Latency: 3 cycles per non-HALT instruction; HALT holds until reset.
// Backpressure: none; sequencing is free-running. Without CPU_CU_BRANCH_EN opcode 0xE is a retiring NOP.
module cpu_cu
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     reset,
    cpu_cu_if.slave  bus
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctrl;
    logic             retire;

    // An instruction retires as it leaves any execute state; HALT entry never counts.
    assign retire = (state_q == ST_ALU)   || (state_q == ST_LOAD) ||
                    (state_q == ST_STORE) || (state_q == ST_BRANCH);

    // Main sequencer plus retired-instruction counter; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
        end else begin
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_RESET:  state_q <= ST_FETCH;
                ST_FETCH:  state_q <= ST_DECODE;
                ST_DECODE: state_q <= op_to_state(bus.IR[15:12]);
                ST_HALT:   state_q <= ST_HALT;
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

`ifdef CPU_CU_BRANCH_EN
    flags_t flags_q;

    // Flags are captured only by ALU instructions, so LOAD/STORE/BRANCH leave them alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (state_q == ST_ALU) begin
            flags_q <= '{n: bus.N, z: bus.Z, c: bus.C};
        end
    end

    logic unused_ir;
    assign unused_ir = ^bus.IR[8:0];

    cpu_cu_decode u_decode (
        .state_i   (state_q),
        .br_cond_i (bus.IR[11:9]),
        .flags_i   (flags_q),
        .ctrl_o    (ctrl)
    );
`else
    logic unused_ir;
    assign unused_ir = ^{bus.IR[11:0], bus.N, bus.Z, bus.C};

    cpu_cu_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );
`endif

    assign bus.W_En      = ctrl.w_en;
    assign bus.S_Sel     = ctrl.s_sel;
    assign bus.pc_ld     = ctrl.pc_ld;
    assign bus.pc_inc    = ctrl.pc_inc;
    assign bus.ir_ld     = ctrl.ir_ld;
    assign bus.adr_sel   = ctrl.adr_sel;
    assign bus.mw_en     = ctrl.mw_en;
    assign bus.halted    = ctrl.halted;
    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_cu.sv
// Directed bench for cpu_cu with a 4-bit retired counter so that wrap is reachable.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Output vector order: {W_En,S_Sel,pc_ld,pc_inc,ir_ld,adr_sel,mw_en,halted}.
module tb_cpu_cu;

    localparam int CW = 4;

    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_FETCH = 8'b0001_1000;
    localparam logic [7:0] O_ALU   = 8'b1000_0000;
    localparam logic [7:0] O_LOAD  = 8'b1100_0100;
    localparam logic [7:0] O_STORE = 8'b0000_0110;
    localparam logic [7:0] O_HALT  = 8'b0000_0001;
`ifdef CPU_CU_BRANCH_EN
    localparam logic [7:0] O_BR_T  = 8'b0010_0000;
`else
    localparam logic [7:0] O_BR_T  = 8'b0000_0000;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_cu_if #(.CNT_W(CW)) bus ();

    cpu_cu #(.CNT_W(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.W_En, bus.S_Sel, bus.pc_ld, bus.pc_inc,
                bus.ir_ld, bus.adr_sel, bus.mw_en, bus.halted};
    endfunction

    task automatic check_cycle(input string tag, input logic [2:0] st, input logic [7:0] o);
        check({tag, "/state"}, 32'(bus.state), 32'(st));
        check({tag, "/outs"},  32'(outs()),    32'(o));
    endtask

    // Entered at a falling edge while in FETCH; leaves at the falling edge of the next FETCH.
    task automatic run_instr(input string tag, input logic [15:0] ir, input logic n, input logic z,
                             input logic c, input logic [2:0] exp_st, input logic [7:0] exp_o,
                             input int exp_cnt);
        check_cycle({tag, "/fetch"}, 3'd1, O_FETCH);
        bus.IR = ir;
        bus.N  = n;
        bus.Z  = z;
        bus.C  = c;
        @(negedge clk);
        check_cycle({tag, "/decode"}, 3'd2, O_NONE);
        @(negedge clk);
        check_cycle({tag, "/exec"}, exp_st, exp_o);
        @(negedge clk);
        check({tag, "/cnt"}, 32'(bus.instr_cnt), 32'(exp_cnt));
    endtask

    initial begin
        bus.IR = 16'h0000;
        bus.N  = 1'b0;
        bus.Z  = 1'b0;
        bus.C  = 1'b0;

        // Reset held for two edges.
        @(negedge clk);
        check_cycle("rst0", 3'd0, O_NONE);
        @(negedge clk);
        check_cycle("rst1", 3'd0, O_NONE);
        check("rst_cnt", 32'(bus.instr_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // ALU op sets fN=1, fZ=0, fC=1.
        run_instr("alu1",  16'h10C8, 1'b1, 1'b0, 1'b1, 3'd3, O_ALU,   1);
        run_instr("load",  16'hC000, 1'b0, 1'b1, 1'b0, 3'd4, O_LOAD,  2);
        run_instr("store", 16'hD000, 1'b0, 1'b1, 1'b0, 3'd5, O_STORE, 3);
        // Flags survive LOAD/STORE/BRANCH.
        run_instr("br_n",  16'hE400, 1'b0, 1'b1, 1'b0, 3'd6, O_BR_T,  4);
        run_instr("br_c",  16'hE600, 1'b0, 1'b1, 1'b0, 3'd6, O_BR_T,  5);
        run_instr("br_z0", 16'hE200, 1'b0, 1'b1, 1'b0, 3'd6, O_NONE,  6);
        run_instr("br_nz", 16'hE800, 1'b0, 1'b1, 1'b0, 3'd6, O_BR_T,  7);
        // ALU with Z=1.
        run_instr("alu2",  16'h2000, 1'b0, 1'b1, 1'b0, 3'd3, O_ALU,   8);
        run_instr("br_z1", 16'hE200, 1'b0, 1'b0, 1'b0, 3'd6, O_BR_T,  9);
        run_instr("br_nv", 16'hEA00, 1'b0, 1'b0, 1'b0, 3'd6, O_NONE,  10);
        run_instr("br_al", 16'hE000, 1'b0, 1'b0, 1'b0, 3'd6, O_BR_T,  11);
        // ALU with Z=0 clears fZ.
        run_instr("alu3",  16'h3000, 1'b0, 1'b0, 1'b0, 3'd3, O_ALU,   12);
        run_instr("br_z2", 16'hE200, 1'b0, 1'b0, 1'b0, 3'd6, O_NONE,  13);
        // Four more: 17 retired in total wraps a 4-bit counter to 1.
        run_instr("wr0",   16'h0000, 1'b0, 1'b0, 1'b0, 3'd3, O_ALU,   14);
        run_instr("wr1",   16'hB000, 1'b0, 1'b0, 1'b0, 3'd3, O_ALU,   15);
        run_instr("wr2",   16'h5000, 1'b0, 1'b0, 1'b0, 3'd3, O_ALU,   0);
        run_instr("wr3",   16'hA000, 1'b0, 1'b0, 1'b0, 3'd3, O_ALU,   1);

        // HALT holds for 10 cycles without counting.
        check_cycle("hlt/fetch", 3'd1, O_FETCH);
        bus.IR = 16'hF000;
        @(negedge clk);
        check_cycle("hlt/decode", 3'd2, O_NONE);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_cycle("hlt/hold", 3'd7, O_HALT);
            check("hlt/cnt", 32'(bus.instr_cnt), 32'd1);
            @(negedge clk);
        end

        // Reset while halted.
        reset = 1'b0;
        @(negedge clk);
        check_cycle("hrst", 3'd0, O_NONE);
        check("hrst/cnt", 32'(bus.instr_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Set all flags, then reset during DECODE of the next instruction.
        run_instr("alu4", 16'h4000, 1'b1, 1'b1, 1'b1, 3'd3, O_ALU, 1);
        check_cycle("mrst/fetch", 3'd1, O_FETCH);
        bus.IR = 16'h2000;
        @(negedge clk);
        check_cycle("mrst/decode", 3'd2, O_NONE);
        reset = 1'b0;
        @(negedge clk);
        check_cycle("mrst", 3'd0, O_NONE);
        check("mrst/cnt", 32'(bus.instr_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Flags were cleared by reset: fN branch not taken, unconditional still taken.
        run_instr("br_rn", 16'hE400, 1'b1, 1'b1, 1'b1, 3'd6, O_NONE, 1);
        run_instr("br_ra", 16'hE000, 1'b1, 1'b1, 1'b1, 3'd6, O_BR_T, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
